// File: rtl/alu_pkg.sv
// Shared types and the ALU reference function used by the self-test sequencer
// and by any future scoreboard that needs the same golden ALU behaviour.
package alu_pkg;

    // Widest operand alu_ref evaluates; callers truncate to their own width.
    localparam int ALU_MAX_W = 32;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } bist_state_t;

    // Low result bits depend only on low operand bits, so truncating the
    // wide result gives the correct mod-2^WIDTH answer for any WIDTH.
    function automatic logic [ALU_MAX_W-1:0] alu_ref(
        input alu_op_t              op,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b
    );
        logic [ALU_MAX_W-1:0] r;
        case (op)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_ADD: r = a + b;
            default: r = a + ~b + ALU_MAX_W'(1);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_selftest_ref.sv
// Combinational reference ALU: a thin wrapper around alu_pkg::alu_ref.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = WIDTH'(alu_ref(alu_op_t'(op), ALU_MAX_W'(a), ALU_MAX_W'(b)));

endmodule

// File: rtl/alu_selftest.sv
// Built-in self-test sequencer: sweeps every {op, A, B} through the ALU,
// compares against the reference model and reports pass/fail counts.
module alu_selftest
    import alu_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 2*WIDTH + 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     A_num,
    output logic [WIDTH-1:0]     B_num,
    output logic [1:0]           ALUControl,
    input  logic [WIDTH-1:0]     result,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     pass_count,
    output logic [CNT_W-1:0]     fail_count,
    output logic                 first_fail_valid,
    output logic [2+3*WIDTH-1:0] first_fail_vec
);

    localparam int IDX_W = 2 + 2*WIDTH;
    localparam int VEC_W = 2 + 3*WIDTH;
    // Settle counter runs 0..SETTLE-1; kept at least one bit wide for SETTLE<=1.
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SET_LAST = (SETTLE > 0) ? SET_W'(SETTLE - 1) : '0;

    bist_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [CNT_W-1:0]  pass_q, pass_d;
    logic [CNT_W-1:0]  fail_q, fail_d;
    logic              ffv_q, ffv_d;
    logic [VEC_W-1:0]  ffvec_q, ffvec_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  ref_y;

    // Reference is taken from the vector actually on the ALU pins.
    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (ref_y)
    );

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case infers a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    idx_d    = '0;
                    settle_d = '0;
                    pass_d   = '0;
                    fail_d   = '0;
                    ffv_d    = 1'b0;
                    ffvec_d  = '0;
                end
            end
            ST_DRIVE: begin
                {op_d, a_d, b_d} = idx_q;
                settle_d         = '0;
                state_d          = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
            end
            ST_WAIT: begin
                if (settle_q == SET_LAST) begin
                    settle_d = '0;
                    state_d  = ST_CHECK;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_CHECK: begin
                if (result == ref_y) begin
                    pass_d = pass_q + CNT_W'(1);
                end else begin
                    fail_d = fail_q + CNT_W'(1);
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = {op_q, a_q, b_q, result};
                    end
                end
                if (&idx_q) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status flags are registered copies of where the FSM is heading.
        busy_d = (state_d == ST_DRIVE) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            ffv_q    <= ffv_d;
            ffvec_q  <= ffvec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign A_num            = a_q;
    assign B_num            = b_q;
    assign ALUControl       = op_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_alu_selftest.sv
// Self-checking bench for alu_selftest: a configurable (optionally faulty) ALU,
// a sweep-level reference model and a done-triggered scoreboard monitor.
`timescale 1ns/1ps
module tb_alu_selftest;

    localparam int W  = 4;
    localparam int N  = 1024;
    localparam int CW = 2*W + 3;
    localparam int VW = 2 + 3*W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start_v = 1'b0;
    always #5 clk = ~clk;

    // ALU fault configuration: 0 good, 1 SUB missing +1, 2 stuck bit, 3 one bad vector
    int mode = 0;
    int sbit = 0;
    int sval = 0;
    int bad_idx = 0;
    int bad_mask = 1;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] golden(int op, int a, int b);
        case (op)
            0:       return 4'(a & b);
            1:       return 4'(a | b);
            2:       return 4'((a + b) % 16);
            default: return 4'((a - b + 16) % 16);
        endcase
    endfunction

    function automatic logic [3:0] alu_fn(logic [1:0] op, logic [3:0] a, logic [3:0] b,
                                          int md, int sb, int sv, int bi, int bm);
        logic [3:0] r;
        r = golden(int'(op), int'(a), int'(b));
        case (md)
            1: if (op == 2'b11) r = 4'((int'(a) - int'(b) - 1 + 32) % 16);
            2: r[sb] = sv[0];
            3: if (int'(op) * 256 + int'(a) * 16 + int'(b) == bi) r = r ^ 4'(bm);
            default: ;
        endcase
        return r;
    endfunction

    // Main DUT, SETTLE=1
    logic [W-1:0] a1, b1, res1;
    logic [1:0] op1;
    logic busy1, done1, ffv1;
    logic [CW-1:0] pass1, fail1;
    logic [VW-1:0] ffvec1;
    assign res1 = alu_fn(op1, a1, b1, mode, sbit, sval, bad_idx, bad_mask);

    alu_selftest #(.WIDTH(W), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A_num(a1), .B_num(b1), .ALUControl(op1), .result(res1),
        .busy(busy1), .done(done1), .pass_count(pass1), .fail_count(fail1),
        .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
    );

    // SETTLE=0 and SETTLE=3 variants
    logic [W-1:0] a0, b0, res0, a3, b3, res3;
    logic [1:0] op0, op3;
    logic busy0, done0, ffv0, busy3, done3, ffv3;
    logic [CW-1:0] pass0, fail0, pass3, fail3;
    logic [VW-1:0] ffvec0, ffvec3;
    assign res0 = alu_fn(op0, a0, b0, mode, sbit, sval, bad_idx, bad_mask);
    assign res3 = alu_fn(op3, a3, b3, mode, sbit, sval, bad_idx, bad_mask);

    alu_selftest #(.WIDTH(W), .SETTLE(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_v),
        .A_num(a0), .B_num(b0), .ALUControl(op0), .result(res0),
        .busy(busy0), .done(done0), .pass_count(pass0), .fail_count(fail0),
        .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
    );

    alu_selftest #(.WIDTH(W), .SETTLE(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_v),
        .A_num(a3), .B_num(b3), .ALUControl(op3), .result(res3),
        .busy(busy3), .done(done3), .pass_count(pass3), .fail_count(fail3),
        .first_fail_valid(ffv3), .first_fail_vec(ffvec3)
    );

    typedef struct {
        int pass;
        int fail;
        bit ffv;
        logic [VW-1:0] ffvec;
        int cycles;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected sweep outcome from the arithmetic rules and the ALU fault setup
    function automatic exp_t model_expect(int settle);
        exp_t e;
        e.pass = 0; e.fail = 0; e.ffv = 1'b0; e.ffvec = '0;
        e.cycles = N * (settle + 2);
        for (int op = 0; op < 4; op++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    logic [3:0] got;
                    got = alu_fn(2'(op), 4'(a), 4'(b), mode, sbit, sval, bad_idx, bad_mask);
                    if (got == golden(op, a, b)) e.pass++;
                    else begin
                        e.fail++;
                        if (!e.ffv) begin
                            e.ffv = 1'b1;
                            e.ffvec = {2'(op), 4'(a), 4'(b), got};
                        end
                    end
                end
        return e;
    endfunction

    // Scoreboard monitor: pops one expectation on every done rise
    int busy_rise = 0;
    logic busy_prev = 1'b0;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (busy1 && !busy_prev) busy_rise = cyc;
            if (done1 && !done_prev) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_done", 64'(sb_q.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_cycles", 64'(cyc - busy_rise), 64'(e.cycles));
                    check("sb_pass", 64'(pass1), 64'(e.pass));
                    check("sb_fail", 64'(fail1), 64'(e.fail));
                    check("sb_ffv", 64'(ffv1), 64'(e.ffv));
                    check("sb_ffvec", 64'(ffvec1), 64'(e.ffvec));
                    check("sb_busy_low", 64'(busy1), 64'd0);
                    check("sb_total", 64'(pass1) + 64'(fail1), 64'(N));
                end
            end
            busy_prev = busy1;
            done_prev = done1;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int n;
        n = 0;
        while (!(done1 && sb_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_done_budget", 64'(n < budget), 64'd1);
        #1;
    endtask

    task automatic run_full();
        sb_q.push_back(model_expect(1));
        pulse_start();
        wait_done(4000);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_A"}, 64'(a1), 64'd0);
        check({tag, "_B"}, 64'(b1), 64'd0);
        check({tag, "_op"}, 64'(op1), 64'd0);
        check({tag, "_busy"}, 64'(busy1), 64'd0);
        check({tag, "_done"}, 64'(done1), 64'd0);
        check({tag, "_pass"}, 64'(pass1), 64'd0);
        check({tag, "_fail"}, 64'(fail1), 64'd0);
        check({tag, "_ffv"}, 64'(ffv1), 64'd0);
        check({tag, "_ffvec"}, 64'(ffvec1), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and idle behaviour
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("idle_busy", 64'(busy1), 64'd0);
        check("idle_done", 64'(done1), 64'd0);

        // Good ALU
        mode = 0;
        run_full();
        check("good_pass", 64'(pass1), 64'd1024);
        check("good_hold_A", 64'(a1), 64'hF);
        check("good_hold_B", 64'(b1), 64'hF);
        check("good_hold_op", 64'(op1), 64'h3);

        // SUB missing +1
        mode = 1;
        run_full();
        check("subfault_fail", 64'(fail1), 64'd256);
        check("subfault_vec", 64'(ffvec1), 64'(14'b11_0000_0000_1111));

        // result[0] stuck at 0
        mode = 2; sbit = 0; sval = 0;
        run_full();
        check("stuck0_fail", 64'(fail1), 64'd512);
        check("stuck0_vec", 64'(ffvec1), 64'(14'b00_0001_0001_0000));

        // Randomised faults
        for (int i = 0; i < 3; i++) begin
            mode = 3;
            bad_idx = int'($urandom_range(0, N - 1));
            bad_mask = int'($urandom_range(1, 15));
            run_full();
        end
        for (int i = 0; i < 2; i++) begin
            mode = 2;
            sbit = int'($urandom_range(0, 3));
            sval = int'($urandom_range(0, 1));
            run_full();
        end

        // start re-pulsed mid-sweep is ignored
        mode = 1;
        sb_q.push_back(model_expect(1));
        pulse_start();
        repeat (98) @(posedge clk);
        pulse_start();
        check("ignore_busy", 64'(busy1), 64'd1);
        wait_done(4000);

        // start in DONE clears results and repeats the sweep
        sb_q.push_back(model_expect(1));
        pulse_start();
        check("restart_pass_clr", 64'(pass1), 64'd0);
        check("restart_fail_clr", 64'(fail1), 64'd0);
        check("restart_ffv_clr", 64'(ffv1), 64'd0);
        check("restart_done_clr", 64'(done1), 64'd0);
        check("restart_busy", 64'(busy1), 64'd1);
        wait_done(4000);

        // Asynchronous reset mid-sweep, then a fresh full run
        mode = 0;
        pulse_start();
        repeat (499) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 check_all_zero("postreset");
        run_full();
        check("postreset_pass", 64'(pass1), 64'd1024);

        // SETTLE=0 and SETTLE=3 timing with a random stuck bit
        begin
            exp_t e0, e3;
            int rise, d0, d3, n;
            mode = 2;
            sbit = int'($urandom_range(0, 3));
            sval = int'($urandom_range(0, 1));
            e0 = model_expect(0);
            e3 = model_expect(3);
            @(posedge clk); #1 start_v = 1'b1;
            @(posedge clk); #1 start_v = 1'b0;
            rise = cyc;
            d0 = -1; d3 = -1; n = 0;
            while ((d0 < 0 || d3 < 0) && n < 8000) begin
                @(negedge clk);
                n++;
                if (done0 && d0 < 0) d0 = cyc;
                if (done3 && d3 < 0) d3 = cyc;
            end
            check("var_budget", 64'(n < 8000), 64'd1);
            check("s0_cycles", 64'(d0 - rise), 64'(e0.cycles));
            check("s3_cycles", 64'(d3 - rise), 64'(e3.cycles));
            check("s0_pass", 64'(pass0), 64'(e0.pass));
            check("s0_fail", 64'(fail0), 64'(e0.fail));
            check("s0_ffvec", 64'(ffvec0), 64'(e0.ffvec));
            check("s3_pass", 64'(pass3), 64'(e3.pass));
            check("s3_fail", 64'(fail3), 64'(e3.fail));
            check("s3_ffvec", 64'(ffvec3), 64'(e3.ffvec));
        end

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
